// File: rtl/nonce_uplink.sv
// nonce_uplink: per-core result capture, round-robin arbiter, FIFO, UART byte serialiser.
// Optional RESULT_TAG_EN prefixes each frame with a {4'hA, channel} tag byte.
module nonce_uplink #(
  parameter int NCH        = 2,
  parameter int NONCE_W    = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*NONCE_W-1:0] nonce_in,
  input  logic [NCH-1:0]         nonce_vld,
  input  logic                   tx_idle,
  output logic                   transmit,
  output logic [7:0]             tx_data,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [DEPTH_LOG2:0]    level,
  output logic [15:0]            drop_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef RESULT_TAG_EN
  localparam int TW = 4;
`else
  localparam int TW = 0;
`endif
  localparam int EW = NONCE_W + TW;
  localparam int NB = NONCE_W / 8 + TW / 4;
  localparam int SW = NB * 8;
  localparam int BW = $clog2(NB + 1);

  logic [NCH-1:0]     pend;
  logic [NONCE_W-1:0] hold [NCH];
  logic [CW-1:0]      rr;
  logic [CW-1:0]      gnt;
  logic               found;
  logic               push;
  logic               pop;
  logic [NCH-1:0]     drain;
  logic [NCH-1:0]     drop;
  logic [4:0]         ndrop;
  logic [16:0]        dsum;

  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(rr) + k;
      if (j >= NCH) j = j - NCH;
      if (!found && pend[j]) begin
        gnt = CW'(j);
        found = 1'b1;
      end
    end
  end

  assign push = found && !fifo_full;

  always_comb begin
    drain = '0;
    drop = '0;
    ndrop = '0;
    for (int i = 0; i < NCH; i++) begin
      drain[i] = push && (gnt == CW'(i));
      drop[i] = nonce_vld[i] && pend[i] && !drain[i];
      ndrop = ndrop + 5'(drop[i]);
    end
  end

  assign dsum = {1'b0, drop_cnt} + 17'(ndrop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      rr <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (nonce_vld[i] && !drop[i]) begin
          pend[i] <= 1'b1;
          hold[i] <= nonce_in[i*NONCE_W +: NONCE_W];
        end else if (drain[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (push)
        rr <= (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end

  logic [EW-1:0] wr_word;
  logic [EW-1:0] head;
  logic [EW-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;

`ifdef RESULT_TAG_EN
  assign wr_word = {4'(gnt), hold[gnt]};
`else
  assign wr_word = hold[gnt];
`endif

  assign head = mem[rp];
  assign fifo_full = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign fifo_empty = (level == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, WAIT_HI} st_t;
  st_t st;
  st_t st_nx;
  logic fire;
  logic [SW-1:0] sr;
  logic [BW-1:0] bc;

  always_comb begin
    st_nx = st;
    pop = 1'b0;
    fire = 1'b0;
    unique case (st)
      IDLE: if (!fifo_empty) begin
        pop = 1'b1;
        st_nx = SEND;
      end
      SEND: if (tx_idle) begin
        fire = 1'b1;
        st_nx = WAIT_LO;
      end
      WAIT_LO: if (!tx_idle) st_nx = WAIT_HI;
      WAIT_HI: if (tx_idle) st_nx = (bc != '0) ? SEND : IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      sr <= '0;
      bc <= '0;
      transmit <= 1'b0;
      tx_data <= '0;
    end else begin
      st <= st_nx;
      transmit <= fire;
      if (pop) begin
`ifdef RESULT_TAG_EN
        sr <= {4'hA, head[EW-1 -: 4], head[NONCE_W-1:0]};
`else
        sr <= head;
`endif
        bc <= BW'(NB);
      end else if (fire) begin
        tx_data <= sr[SW-1 -: 8];
        sr <= {sr[SW-9:0], 8'h00};
        bc <= bc - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nonce_uplink.sv
// tb_nonce_uplink: scoreboard bench for nonce_uplink with a small UART busy model.
// Expected bytes are queued as pulses are driven and matched against captured strobes.
`timescale 1ns/1ps
module tb_nonce_uplink;
  localparam int NCH = 2;
  localparam int NW = 64;
  localparam int DL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH*NW-1:0] nonce_in = '0;
  logic [NCH-1:0] nonce_vld = '0;
  logic tx_idle = 1'b1;
  logic transmit;
  logic [7:0] tx_data;
  logic fifo_full;
  logic fifo_empty;
  logic [DL:0] level;
  logic [15:0] drop_cnt;

  nonce_uplink #(.NCH(NCH), .NONCE_W(NW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .nonce_in(nonce_in), .nonce_vld(nonce_vld),
    .tx_idle(tx_idle), .transmit(transmit), .tx_data(tx_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  bit tx_hold = 1'b0;
  int busy = 0;

  // UART model: busy for 3 cycles after each accepted byte
  always @(negedge clk) begin
    if (rst) busy = 0;
    else if (transmit) begin
      rx_q.push_back(tx_data);
      busy = 3;
    end else if (busy > 0) busy--;
    tx_idle = !tx_hold && (busy == 0);
  end

  task automatic push_frame(input int ch, input logic [NW-1:0] v);
`ifdef RESULT_TAG_EN
    exp_q.push_back({4'hA, 4'(ch)});
`endif
    for (int b = NW/8 - 1; b >= 0; b--) exp_q.push_back(v[b*8 +: 8]);
  endtask

  task automatic pulse(input logic [1:0] m,
                       input logic [NW-1:0] v0,
                       input logic [NW-1:0] v1);
    @(negedge clk);
    nonce_in = {v1, v0};
    nonce_vld = m;
    @(negedge clk);
    nonce_vld = '0;
  endtask

  task automatic wait_frames(input int budget, output bit ok);
    int n;
    n = 0;
    while (rx_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (rx_q.size() >= exp_q.size());
    repeat (30) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (transmit !== 1'b0) begin
      n_fail++; $display("FAIL reset_transmit got %b want 0", transmit);
    end
    n_chk++;
    if (tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data);
    end
    n_chk++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", fifo_empty, fifo_full);
    end
    n_chk++;
    if (level !== '0 || drop_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_counts got lvl=%0d drop=%0d want 0 0", level, drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [NW-1:0] v;
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    v = 64'h0123456789ABCDEF;
    push_frame(0, v);
    @(negedge clk);
    nonce_in[0 +: NW] = v;
    nonce_vld = 2'b01;
    @(negedge clk);
    nonce_vld = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (transmit !== 1'b0) begin
      n_fail++; $display("FAIL latency_early got %b want 0", transmit);
    end
    @(negedge clk);
    n_chk++;
    if (transmit !== 1'b1) begin
      n_fail++; $display("FAIL latency_t4 got %b want 1", transmit);
    end
    wait_frames(400, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL single_timeout got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      b = rx_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (b !== e) begin
        n_fail++; $display("FAIL single_byte got %h want %h", b, e);
      end
    end
    n_chk++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL single_count got %0d extra want 0", rx_q.size());
    end
    n_chk++;
    if (fifo_empty !== 1'b1 || drop_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL single_after got e=%b drop=%0d want e=1 drop=0", fifo_empty, drop_cnt);
    end
  endtask

  task automatic test_rr();
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    do_reset();
    push_frame(0, 64'hA);
    push_frame(1, 64'hB);
    pulse(2'b11, 64'hA, 64'hB);
    push_frame(0, 64'hC);
    pulse(2'b01, 64'hC, 64'h0);
    // pointer now sits on channel 1, so ch1 wins the second pair
    push_frame(1, 64'hE);
    push_frame(0, 64'hD);
    pulse(2'b11, 64'hD, 64'hE);
    wait_frames(2000, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL rr_timeout got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      b = rx_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (b !== e) begin
        n_fail++; $display("FAIL rr_byte got %h want %h", b, e);
      end
    end
    n_chk++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rr_count got %0d extra want 0", rx_q.size());
    end
  endtask

  task automatic test_tag();
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    push_frame(1, 64'hFFEE);
    pulse(2'b10, 64'h0, 64'hFFEE);
    wait_frames(600, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL tag_timeout got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      b = rx_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (b !== e) begin
        n_fail++; $display("FAIL tag_byte got %h want %h", b, e);
      end
    end
    n_chk++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL tag_count got %0d extra want 0", rx_q.size());
    end
  endtask

  task automatic test_drain_capture();
    logic [7:0] b;
    logic [7:0] e;
    logic [15:0] d0;
    bit ok;
    d0 = drop_cnt;
    push_frame(0, 64'h5555_0000_0000_0001);
    push_frame(0, 64'h6666_0000_0000_0002);
    @(negedge clk);
    nonce_in[0 +: NW] = 64'h5555_0000_0000_0001;
    nonce_vld = 2'b01;
    @(negedge clk);
    nonce_in[0 +: NW] = 64'h6666_0000_0000_0002;
    @(negedge clk);
    nonce_vld = '0;
    @(negedge clk);
    n_chk++;
    if (drop_cnt !== d0) begin
      n_fail++; $display("FAIL drain_drop got %0d want %0d", drop_cnt, d0);
    end
    wait_frames(1000, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL drain_timeout got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      b = rx_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (b !== e) begin
        n_fail++; $display("FAIL drain_byte got %h want %h", b, e);
      end
    end
    n_chk++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain_count got %0d extra want 0", rx_q.size());
    end
  endtask

  task automatic test_fill_drop();
    logic [7:0] b;
    logic [7:0] e;
    logic [NW-1:0] v;
    logic [15:0] d0;
    bit ok;
    d0 = drop_cnt;
    tx_hold = 1'b1;
    repeat (3) @(negedge clk);
    // first word parks in the serialiser, the next 16 fill the FIFO
    for (int i = 0; i < 17; i++) begin
      v = 64'hC0DE_0000_0000_0000 | 64'(i);
      push_frame(i % 2, v);
      if (i % 2 == 0) pulse(2'b01, v, 64'h0);
      else pulse(2'b10, 64'h0, v);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (level !== 5'd16 || fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_level got lvl=%0d f=%b want lvl=16 f=1", level, fifo_full);
    end
    pulse(2'b01, 64'hAAAA_0000_0000_00A0, 64'h0);
    pulse(2'b01, 64'hBAD0_0000_0000_0001, 64'h0);
    @(negedge clk);
    n_chk++;
    if (drop_cnt !== d0 + 16'd1) begin
      n_fail++; $display("FAIL drop_one got %0d want %0d", drop_cnt, d0 + 16'd1);
    end
    pulse(2'b10, 64'h0, 64'hBBBB_0000_0000_00B1);
    pulse(2'b11, 64'hBAD0_0000_0000_0002, 64'hBAD0_0000_0000_0003);
    @(negedge clk);
    n_chk++;
    if (drop_cnt !== d0 + 16'd3) begin
      n_fail++; $display("FAIL drop_multi got %0d want %0d", drop_cnt, d0 + 16'd3);
    end
    push_frame(1, 64'hBBBB_0000_0000_00B1);
    push_frame(0, 64'hAAAA_0000_0000_00A0);
    tx_hold = 1'b0;
    wait_frames(5000, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL fill_timeout got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      b = rx_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (b !== e) begin
        n_fail++; $display("FAIL fill_byte got %h want %h", b, e);
      end
    end
    n_chk++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL fill_count got %0d extra want 0", rx_q.size());
    end
    n_chk++;
    if (fifo_empty !== 1'b1 || level !== '0) begin
      n_fail++; $display("FAIL fill_drained got lvl=%0d want 0", level);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic [7:0] e;
    int n;
    bit ok;
    pulse(2'b11, 64'hDEAD_BEEF_CAFE_F00D, 64'h7777_0000_0000_0007);
    n = 0;
    while (rx_q.size() < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (rx_q.size() < 3) begin
      n_fail++; $display("FAIL mid_timeout got %0d want 3", rx_q.size());
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (transmit !== 1'b0 || level !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got tx=%b lvl=%0d want tx=0 lvl=0", transmit, level);
    end
    n_chk++;
    if (fifo_empty !== 1'b1 || drop_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_flags got e=%b drop=%0d want e=1 drop=0", fifo_empty, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    repeat (40) @(negedge clk);
    n_chk++;
    if (rx_q.size() != 0) begin
      n_fail++; $display("FAIL mid_quiet got %0d bytes want 0", rx_q.size());
    end
    push_frame(0, 64'h1122334455667788);
    pulse(2'b01, 64'h1122334455667788, 64'h0);
    wait_frames(600, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL mid_new_timeout got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      b = rx_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (b !== e) begin
        n_fail++; $display("FAIL mid_byte got %h want %h", b, e);
      end
    end
    n_chk++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL mid_count got %0d extra want 0", rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_tag();
    test_drain_capture();
    test_fill_drop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
